// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and defaults for the pipeline stage register.
//   pipe_state_e : occupancy state (EMPTY / FULL / SKID)
//   CTRL_W_DEF   : default control bundle width
//   DATA_W_DEF   : default data bundle width
package pipe_pkg;
  localparam int CTRL_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: upstream/downstream valid-ready handshake of one stage.
//   in_valid/in_ready/in_ctrl/in_data     : upstream side
//   out_valid/out_ready/out_ctrl/out_data : downstream side
//   modport master : environment (drives in_*, out_ready)
//   modport slave  : the stage    (drives in_ready, out_*)
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_slot.sv
// pipe_slot: one storage entry (valid flag, ctrl, data).
//   clk, reset : clock, async active-high reset
//   i_clear    : invalidate entry and zero ctrl (wins over i_load)
//   i_load     : capture i_ctrl/i_data and mark valid
//   o_valid/o_ctrl/o_data : registered entry contents
// ctrl is zeroed whenever the entry goes invalid so bubbles never carry
// write enables; data is left as-is to save toggling.
module pipe_slot #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);
  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush and bubble zeroing.
//   clk   : clock, rising edge
//   reset : async active-high reset
//   flush : drop held entries and the beat offered this cycle
//   bus   : pipe_stage_reg_if.slave (in_* upstream, out_* downstream)
// Build option: define PIPE_STAGE_SKID_EN to add a second (skid) entry and
// make in_ready a register with no combinational path from out_ready.
// Without it, in_ready = !out_valid || out_ready and there is one entry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus
);
  pipe_state_e       r_state, w_state_nxt;
  logic              w_acc, w_drain;
  logic              w_out_load, w_out_clear, w_out_valid;
  logic [CTRL_W-1:0] w_out_ctrl_in, w_out_ctrl;
  logic [DATA_W-1:0] w_out_data_in, w_out_data;

  // A beat offered during flush is never taken.
  assign w_acc   = bus.in_valid && bus.in_ready && !flush;
  assign w_drain = w_out_valid && bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              w_skid_load, w_skid_clear, w_skid_valid;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;
  logic              r_in_ready;

  // Older beat sits in the skid entry whenever it is occupied, so the output
  // refills from it before anything new is taken.
  assign w_out_ctrl_in = w_skid_valid ? w_skid_ctrl : bus.in_ctrl;
  assign w_out_data_in = w_skid_valid ? w_skid_data : bus.in_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid_slot (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_ctrl  (bus.in_ctrl),
    .i_data  (bus.in_data),
    .o_valid (w_skid_valid),
    .o_ctrl  (w_skid_ctrl),
    .o_data  (w_skid_data)
  );

  // Resets high but is masked by reset, so the first edge after release
  // can already accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_in_ready <= 1'b1;
    else       r_in_ready <= (w_state_nxt != SKID);
  end

  assign bus.in_ready = r_in_ready && !reset;
`else
  assign w_out_ctrl_in = bus.in_ctrl;
  assign w_out_data_in = bus.in_data;
  assign bus.in_ready  = !reset && (!w_out_valid || bus.out_ready);
`endif

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_out_slot (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_out_load),
    .i_clear (w_out_clear),
    .i_ctrl  (w_out_ctrl_in),
    .i_data  (w_out_data_in),
    .o_valid (w_out_valid),
    .o_ctrl  (w_out_ctrl),
    .o_data  (w_out_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_out_load  = 1'b0;
    w_out_clear = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
`endif
    if (flush) begin
      // Any drain this cycle still completes; everything held is dropped.
      w_state_nxt = EMPTY;
      w_out_clear = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
      w_skid_clear = 1'b1;
`endif
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_acc) begin
            w_state_nxt = FULL;
            w_out_load  = 1'b1;
          end
        end
        FULL: begin
          if (w_acc && w_drain) begin
            w_out_load = 1'b1;
          end else if (w_acc) begin
`ifdef PIPE_STAGE_SKID_EN
            w_state_nxt = SKID;
            w_skid_load = 1'b1;
`else
            // in_ready implies out_ready here, so this arm is not reached.
            w_out_load = 1'b1;
`endif
          end else if (w_drain) begin
            w_state_nxt = EMPTY;
            w_out_clear = 1'b1;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        SKID: begin
          // in_ready is low here, so only a drain can happen.
          if (w_drain) begin
            w_state_nxt  = FULL;
            w_out_load   = 1'b1;
            w_skid_clear = 1'b1;
          end
        end
`endif
        default: begin
          w_state_nxt = EMPTY;
          w_out_clear = 1'b1;
        end
      endcase
    end
  end

  assign bus.out_valid = w_out_valid;
  assign bus.out_ctrl  = w_out_ctrl;
  assign bus.out_data  = w_out_data;
endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID_MODE = 1'b1;
`else
  localparam bit SKID_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(32)) bus ();

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_ctrl = '0; bus.in_data = '0; bus.out_ready = 1'b0;
    #2;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_ctrl !== 8'h00) begin errors++; $display("FAIL reset_out_ctrl: got %h want 00", bus.out_ctrl); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_ctrl = 8'hA5; bus.in_data = 32'h1234_5678; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.out_ctrl !== 8'hA5) begin errors++; $display("FAIL basic_ctrl: got %h want a5", bus.out_ctrl); end
    checks++; if (bus.out_data !== 32'h1234_5678) begin errors++; $display("FAIL basic_data: got %h want 12345678", bus.out_data); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 8'h00) begin errors++; $display("FAIL basic_bubble: got v=%b c=%h want v=0 c=00", bus.out_valid, bus.out_ctrl); end
  endtask

  task automatic test_stall();
    logic [31:0] got[$];
    int p;
    bit fi;
    logic exp_rdy;
    logic [31:0] act;
    // cycle A: beat 1 into an empty stage
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'd1; bus.in_ctrl = 8'h11;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_rdy_a: got %b want 1", bus.in_ready); end
    // cycle B: beat 2 offered; only the skid build takes it
    @(negedge clk);
    bus.in_data = 32'd2; bus.in_ctrl = 8'h12;
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd1) begin errors++; $display("FAIL stall_hold_b: got v=%b d=%0d want v=1 d=1", bus.out_valid, bus.out_data); end
    exp_rdy = SKID_MODE;
    checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL stall_rdy_b: got %b want %b", bus.in_ready, exp_rdy); end
    // cycle C
    @(negedge clk);
    p = SKID_MODE ? 3 : 2;
    bus.in_data = p; bus.in_ctrl = 8'(8'h10 + p);
    #1;
    checks++; if (bus.out_data !== 32'd1 || bus.out_ctrl !== 8'h11) begin errors++; $display("FAIL stall_hold_c: got d=%0d c=%h want d=1 c=11", bus.out_data, bus.out_ctrl); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_rdy_c: got %b want 0", bus.in_ready); end
    // cycle D: third stalled cycle, then release
    @(negedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd1) begin errors++; $display("FAIL stall_hold_d: got v=%b d=%0d want v=1 d=1", bus.out_valid, bus.out_data); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_rdy_d: got %b want 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      fi = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
      @(negedge clk);
      if (fi) begin
        if (p == 3) bus.in_valid = 1'b0;
        else begin p++; bus.in_data = p; bus.in_ctrl = 8'(8'h10 + p); end
      end
    end
    checks++; if (got.size() !== 3) begin errors++; $display("FAIL stall_drain_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      act = (i < got.size()) ? got[i] : 32'hFFFF_FFFF;
      checks++; if (act !== 32'(i + 1)) begin errors++; $display("FAIL stall_drain_order[%0d]: got %0d want %0d", i, act, i + 1); end
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_ctrl = 8'h21; bus.in_data = 32'h21;
    @(negedge clk);
    bus.in_ctrl = 8'h22; bus.in_data = 32'h22;
    @(negedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_ctrl !== 8'h21) begin errors++; $display("FAIL flush_setup: got v=%b c=%h want v=1 c=21", bus.out_valid, bus.out_ctrl); end
    flush = 1'b1; bus.in_ctrl = 8'h23; bus.in_data = 32'h23;
    @(negedge clk);
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_ctrl !== 8'h00) begin errors++; $display("FAIL flush_ctrl: got %h want 00", bus.out_ctrl); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost[%0d]: got valid=%b data=%h want valid=0", c, bus.out_valid, bus.out_data); end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int k = 0; k <= 100; k++) begin
      if (k < 100) begin
        bus.in_valid = 1'b1; bus.in_data = k; bus.in_ctrl = 8'(k + 1);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (k < 100) begin
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_rdy[%0d]: got %b want 1", k, bus.in_ready); end
      end
      if (k > 0) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'(k - 1) || bus.out_ctrl !== 8'(k)) begin
          errors++; $display("FAIL b2b_beat[%0d]: got v=%b d=%0d c=%h want v=1 d=%0d c=%h", k - 1, bus.out_valid, bus.out_data, bus.out_ctrl, k - 1, 8'(k));
        end
      end
      @(negedge clk);
    end
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_stall();
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_ctrl = 8'hFF; bus.in_data = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_ctrl !== 8'hFF) begin errors++; $display("FAIL rst_stall_setup: got %h want ff", bus.out_ctrl); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_ctrl !== 8'h00) begin errors++; $display("FAIL rst_async_ctrl: got %h want 00", bus.out_ctrl); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL rst_async_data: got %h want 0", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_async_rdy: got %b want 0", bus.in_ready); end
    @(negedge clk);
    reset = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_partial: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_after_rdy: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_random();
    logic [39:0] q[$];
    logic [31:0] seq = 32'h1000;
    logic exp_rdy;
    bit fi, fo;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      seq++;
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_data   = seq;
      bus.in_ctrl   = 8'(seq * 7 + 3);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      flush         = ($urandom_range(0, 19) == 0);
      #1;
      checks++;
      if (bus.out_valid !== (q.size() != 0)) begin
        errors++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, bus.out_valid, q.size() != 0);
      end
      checks++;
      if (q.size() != 0) begin
        if ({bus.out_ctrl, bus.out_data} !== q[0]) begin
          errors++; $display("FAIL rnd_beat@%0d: got %h want %h", cyc, {bus.out_ctrl, bus.out_data}, q[0]);
        end
      end else if (bus.out_ctrl !== 8'h00) begin
        errors++; $display("FAIL rnd_bubble_ctrl@%0d: got %h want 00", cyc, bus.out_ctrl);
      end
      exp_rdy = SKID_MODE ? (q.size() < 2) : (q.size() == 0 || bus.out_ready);
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        errors++; $display("FAIL rnd_in_ready@%0d: got %b want %b", cyc, bus.in_ready, exp_rdy);
      end
      fo = (q.size() != 0) && bus.out_ready;
      fi = bus.in_valid && exp_rdy && !flush;
      if (fo) void'(q.pop_front());
      if (flush) q.delete();
      else if (fi) q.push_back({bus.in_ctrl, bus.in_data});
    end
    @(negedge clk);
    flush = 1'b0; bus.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
